// File: rtl/pkt_hdr_loader.sv
// Purpose : captures the first HDR_BYTES bytes of a beat-stream packet (zero padded) for the match-action processor.
// Latency : last beat accepted in cycle N -> start_o in N+1 if proc_ready_i; ready seen in BUSY cycle M -> s_ready in M+1.
// Backpr. : s_ready=1 only in IDLE/LOAD/DRAIN (never bubbles mid-packet); held 0 from ISSUE until the processor is done.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   s_valid/s_ready      input beat handshake; s_data bytes (byte 0 earliest), s_bytes valid count, s_last end of packet
//   start_o              one-cycle start pulse, proc_ready_i processor idle/done
//   hdr_o/hdr_len_o      captured header and number of captured bytes; trunc_o packet exceeded HDR_BYTES
//   busy_o               not idle; pkt_cnt_o packets completed, drop_cnt_o zero-length packets dropped
module pkt_hdr_loader #(
  parameter int DATA_BYTES = 8,
  parameter int HDR_BYTES  = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [8*DATA_BYTES-1:0]       s_data,
  input  logic [$clog2(DATA_BYTES):0]   s_bytes,
  input  logic                          s_last,
  output logic                          start_o,
  input  logic                          proc_ready_i,
  output logic [8*HDR_BYTES-1:0]        hdr_o,
  output logic [$clog2(HDR_BYTES):0]    hdr_len_o,
  output logic                          trunc_o,
  output logic                          busy_o,
  output logic [31:0]                   pkt_cnt_o,
  output logic [31:0]                   drop_cnt_o
);

  localparam int BW = $clog2(DATA_BYTES) + 1;
  localparam int PW = $clog2(HDR_BYTES) + 1;
  localparam int SW = PW + 1;  // room for ptr + beat bytes before saturation

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] ISSUE = 3'd3;
  localparam logic [2:0] BUSY  = 3'd4;
  localparam logic [2:0] GUARD = 3'd5;

  logic [2:0]              state;
  logic [PW-1:0]           ptr;
  logic                    trunc;
  logic [8*HDR_BYTES-1:0]  hdr;
  logic [31:0]             pkt_cnt;
  logic [31:0]             drop_cnt;

  logic                    accept;
  logic [BW-1:0]           nb;
  logic [PW-1:0]           base;
  logic [SW-1:0]           sum;
  logic                    ovf;
  logic [PW-1:0]           ptr_nxt;
  logic [8*HDR_BYTES-1:0]  hdr_nxt;
  int                      wr_idx;

  // rst_n gates s_ready so no beat is ever acknowledged while in reset.
  assign s_ready   = rst_n & ((state == IDLE) | (state == LOAD) | (state == DRAIN));
  assign accept    = s_valid & s_ready;
  assign start_o   = (state == ISSUE) & proc_ready_i;
  assign busy_o    = (state != IDLE);
  assign hdr_o     = hdr;
  assign hdr_len_o = ptr;
  assign trunc_o   = trunc;
  assign pkt_cnt_o = pkt_cnt;
  assign drop_cnt_o = drop_cnt;

  // Beat write path. A first beat (IDLE) starts from a cleared header at
  // offset 0. In DRAIN ptr is already HDR_BYTES, so every lane falls past the
  // end: nothing is written and ovf flags any non-empty beat as truncation.
  always_comb begin
    nb      = (s_bytes > BW'(DATA_BYTES)) ? BW'(DATA_BYTES) : s_bytes;
    base    = (state == IDLE) ? '0 : ptr;
    sum     = {1'b0, base} + SW'(nb);
    ovf     = (sum > SW'(HDR_BYTES));
    ptr_nxt = ovf ? PW'(HDR_BYTES) : sum[PW-1:0];
    hdr_nxt = (state == IDLE) ? '0 : hdr;
    wr_idx  = 0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      wr_idx = int'(base) + i;
      if ((BW'(i) < nb) && (wr_idx < HDR_BYTES)) begin
        hdr_nxt[wr_idx*8 +: 8] = s_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      trunc    <= 1'b0;
      hdr      <= '0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      case (state)
        IDLE, LOAD, DRAIN: begin
          if (accept) begin
            hdr   <= hdr_nxt;
            ptr   <= ptr_nxt;
            trunc <= ((state == IDLE) ? 1'b0 : trunc) | ovf;
            if (s_last) begin
              if (ptr_nxt == '0) begin
                // Zero-length packet: header stays cleared, no start issued.
                state    <= IDLE;
                drop_cnt <= drop_cnt + 32'd1;
              end else begin
                state <= ISSUE;
              end
            end else if (ptr_nxt == PW'(HDR_BYTES)) begin
              state <= DRAIN;
            end else begin
              state <= LOAD;
            end
          end
        end
        ISSUE: begin
          if (proc_ready_i) state <= GUARD;
        end
        // The processor still shows ready the cycle it samples start.
        GUARD: state <= BUSY;
        BUSY: begin
          if (proc_ready_i) begin
            state   <= IDLE;
            pkt_cnt <= pkt_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pkt_hdr_loader.md
Name: pkt_hdr_loader

Overview:
- Upstream feeder for the match-action processor.
- Accepts a packet as a beat stream with valid/ready handshake.
- Captures the first HDR_BYTES bytes into a header register and zero-pads short packets. Discards bytes beyond the header.
- Pulses start to the processor, then holds the header stable until the processor returns ready. Keeps packet/drop statistics.

Parameters:
DATA_BYTES, 8, bytes per input beat (power of 2, 1..HDR_BYTES)
HDR_BYTES, 64, header bytes presented to the processor (multiple of DATA_BYTES)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid&s_ready
s_data  in  8*DATA_BYTES  beat bytes; byte i = s_data[8i+7:8i]; lower i is earlier in the packet
s_bytes  in  clog2(DATA_BYTES)+1  valid byte count of the beat, taken from byte 0 upward
s_last  in  1  final beat of the packet
start_o  out  1  one-cycle start pulse to the processor
proc_ready_i  in  1  processor idle / done
hdr_o  out  8*HDR_BYTES  header; byte k = hdr_o[8k+7:8k], maps to processor packet_header_k
hdr_len_o  out  clog2(HDR_BYTES)+1  bytes captured, max HDR_BYTES
trunc_o  out  1  current packet was longer than HDR_BYTES
busy_o  out  1  state != IDLE
pkt_cnt_o  out  32  packets completed by the processor, wraps
drop_cnt_o  out  32  zero-length packets dropped, wraps

Behaviour:
- Reset (async assert, sync deassert use):
  - State IDLE.
  - Outputs cleared: hdr_o, hdr_len_o, trunc_o, pkt_cnt_o, drop_cnt_o, start_o = 0.
  - s_ready=0 while rst_n=0.
  - Reset mid-packet abandons the packet: no start, no count.
- States: IDLE, LOAD, DRAIN, ISSUE, BUSY, GUARD.
- s_ready is 1 in IDLE, LOAD and DRAIN; 0 otherwise.
- Beat length: s_bytes > DATA_BYTES is clamped to DATA_BYTES. s_bytes=0 contributes no bytes.
- IDLE, first beat accepted:
  - Clear the whole header, then write the beat bytes at offset 0.
  - ptr = bytes; trunc=0.
- LOAD, each accepted beat:
  - Write bytes at hdr[ptr..].
  - Bytes at index >= HDR_BYTES are discarded and set trunc=1.
  - ptr saturates at HDR_BYTES.
- DRAIN: accepted beats are discarded and set trunc=1 if bytes>0.
- Transitions on an accepted beat in IDLE, LOAD or DRAIN:
  - s_last and total bytes = 0 → drop_cnt+1, go to IDLE (no start). hdr_o is left zeroed.
  - s_last otherwise → ISSUE.
  - ptr == HDR_BYTES → DRAIN.
  - Otherwise → LOAD.
- hdr_len_o = ptr; trunc_o = trunc. Both update with the header writes.
- ISSUE: start_o = (state==ISSUE) & proc_ready_i, combinational. On start_o → GUARD.
- GUARD: one cycle. proc_ready_i is ignored here, because the processor deasserts ready the cycle after sampling start. → BUSY.
- BUSY: when proc_ready_i=1 → IDLE, pkt_cnt+1.
- Latency:
  - Last beat accepted in cycle N → ISSUE in N+1; start_o in N+1 if proc_ready_i=1.
  - Processor ready seen in BUSY cycle M → s_ready=1 in M+1.
- hdr_o, hdr_len_o and trunc_o stay constant from ISSUE until the next packet's first beat is accepted.
- Counters wrap 0xFFFFFFFF→0.
- s_data and s_last are ignored when s_valid=0.
- No bubbles between beats while in LOAD or DRAIN.

Test Plan:
- 64-byte packet, 8 beats of 8 bytes, bytes 0x00..0x3F, proc_ready_i=1:
  - start_o pulses 1 cycle after the last beat.
  - hdr byte k = k; hdr_len_o=64; trunc_o=0.
  - Processor ready returns 5 cycles later → pkt_cnt_o=1, s_ready=1.
- 100-byte packet (13 beats, last s_bytes=4):
  - s_ready stays 1 through all beats.
  - hdr = first 64 bytes; hdr_len_o=64; trunc_o=1; single start.
- 20-byte packet (beats of 8, 8, 4, s_last on the third):
  - hdr bytes 0..19 = data, bytes 20..63 = 0; hdr_len_o=20.
  - A preceding packet's residue must not leak into bytes 20..63.
- Single beat, s_last=1, s_bytes=0 → no start_o, drop_cnt_o=1, back in IDLE next cycle.
- proc_ready_i held 0 for 10 cycles after the last beat:
  - Stays in ISSUE, s_ready=0, hdr_o stable.
  - proc_ready_i rises → start_o exactly once; GUARD ignores the ready level.
- rst_n pulsed low after 3 beats of a packet:
  - All outputs 0 immediately, no start.
  - A following 8-byte packet loads cleanly with hdr_len_o=8.
